// File: rtl/count_order_mod.sv
// count_order_mod: bidirectional mod/saturating counter with load; `define COUNT_STEP_EN adds a step-size input
module count_order_mod #(
    parameter int WIDTH = 8,
    parameter longint unsigned MOD_MAX = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RST_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] vi,
`ifdef COUNT_STEP_EN
    input  logic [WIDTH-1:0] step,
`endif
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH:0]   maxv = MOD_MAX[WIDTH:0];
    localparam logic [WIDTH-1:0] rstv = RST_VAL[WIDTH-1:0];
    logic [WIDTH:0]   cur, stp, vin, up_sum;
    logic             up_ovf, dn_und;
    logic [WIDTH-1:0] up_v, dn_v, ld_v, nxt;
    logic             nwrap;
    assign cur = {1'b0, out};
    assign vin = {1'b0, vi};
`ifdef COUNT_STEP_EN
    assign stp = {1'b0, step};
`else
    assign stp = (WIDTH+1)'(1);
`endif
    // all arithmetic is WIDTH+1 bits wide so out+step never aliases past 2^WIDTH
    assign up_sum = cur + stp;
    assign up_ovf = up_sum > maxv;
    assign dn_und = stp > cur;
    assign up_v   = up_ovf ? (mode ? maxv[WIDTH-1:0] : WIDTH'(up_sum - maxv - 1'b1)) : WIDTH'(up_sum);
    assign dn_v   = dn_und ? (mode ? '0 : WIDTH'(cur + maxv + 1'b1 - stp)) : WIDTH'(cur - stp);
    assign ld_v   = vin > maxv ? maxv[WIDTH-1:0] : vi;
    always_comb begin
        nxt   = load ? ld_v : en ? (dir ? up_v : dn_v) : out;
        nwrap = !load && en && !mode && (dir ? up_ovf : dn_und);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            out  <= rstv;
            wrap <= 1'b0;
        end else begin
            out  <= nxt;
            wrap <= nwrap;
        end
    end
    assign tc = dir ? (cur == maxv) : (out == '0);
endmodule
